// File: rtl/wb_arbiter_pkg.sv
// Shared types and round-robin pick helpers for the Wishbone arbiter.
// Helpers work on a fixed 32-wide request vector; callers zero-pad narrower ones.
package wb_arbiter_pkg;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } wb_arb_state_e;

  // First requester found scanning last+1, last+2, ... (mod n), returned one-hot.
  function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                  input int unsigned         last,
                                                  input int unsigned         n);
    logic [RR_MAX_N-1:0] gnt;
    logic                found;
    logic                hit;
    logic [RR_IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
      idx      = RR_IDX_W'((last + k) % n);
      hit      = (k <= n) && !found && req[idx];
      gnt[idx] = gnt[idx] | hit;
      found    = found | hit;
    end
    return gnt;
  endfunction

  function automatic logic [RR_IDX_W-1:0] rr_index(input logic [RR_MAX_N-1:0] onehot);
    logic [RR_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      idx = idx | ({RR_IDX_W{onehot[i]}} & RR_IDX_W'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_core.sv
// Combinational N-way round-robin picker: first requester after the last owner wins.
module wb_rr_arbiter_core
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [RR_MAX_N-1:0] req_pad_s;
  logic [RR_MAX_N-1:0] gnt_pad_s;

  // Pad to the helper width, pick, and return both one-hot and encoded winner.
  always_comb begin
    req_pad_s        = '0;
    req_pad_s[N-1:0] = req_i;
    gnt_pad_s        = rr_pick(req_pad_s, 32'(last_i), N);
    gnt_o            = gnt_pad_s[N-1:0];
    gnt_idx_o        = IDX_W'(rr_index(gnt_pad_s));
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave among N_MASTERS masters.
// A grant is held for the whole CYC; one idle clock separates successive owners.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS     = 2,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_MASTERS-1:0]                     m_cyc,
  input  logic [N_MASTERS-1:0]                     m_stb,
  input  logic [N_MASTERS-1:0]                     m_we,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]       m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]       m_dat_w,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0]   m_sel,
  output logic [WB_DATA_WIDTH-1:0]                 m_dat_r,
  output logic [N_MASTERS-1:0]                     m_ack,
  output logic [N_MASTERS-1:0]                     m_err,
  output logic                                     s_cyc,
  output logic                                     s_stb,
  output logic                                     s_we,
  output logic [WB_ADDR_WIDTH-1:0]                 s_adr,
  output logic [WB_DATA_WIDTH-1:0]                 s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]               s_sel,
  input  logic [WB_DATA_WIDTH-1:0]                 s_dat_r,
  input  logic                                     s_ack,
  input  logic                                     s_err,
  output logic [N_MASTERS-1:0]                     grant
);

  localparam int unsigned AW    = WB_ADDR_WIDTH;
  localparam int unsigned DW    = WB_DATA_WIDTH;
  localparam int unsigned SW    = WB_DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  wb_arb_state_e        state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     last_q;
  logic [N_MASTERS-1:0] pick_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 busy_s;
  logic                 owner_cyc_s;

  wb_rr_arbiter_core #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_core (
    .req_i     (m_cyc),
    .last_i    (last_q),
    .gnt_o     (pick_s),
    .gnt_idx_o (pick_idx_s)
  );

  // Ownership FSM: grant on any request when idle, release when the owner drops CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|m_cyc) begin
            grant_q <= pick_s;
            owner_q <= pick_idx_s;
            state_q <= ARB_BUSY;
          end else begin
            grant_q <= '0;
          end
        end
        ARB_BUSY: begin
          if (!owner_cyc_s) begin
            last_q  <= owner_q;
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end else begin
            grant_q <= grant_q;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // AND-OR muxes keyed by the registered grant, so nothing reaches the slave when idle.
  always_comb begin
    busy_s      = (state_q == ARB_BUSY);
    owner_cyc_s = |(m_cyc & grant_q);
    s_cyc       = busy_s & owner_cyc_s;
    s_stb       = busy_s & |(m_stb & grant_q);
    s_we        = busy_s & |(m_we & grant_q);
    s_adr       = '0;
    s_dat_w     = '0;
    s_sel       = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      s_adr   = s_adr   | (m_adr[i*AW +: AW]   & {AW{busy_s & grant_q[i]}});
      s_dat_w = s_dat_w | (m_dat_w[i*DW +: DW] & {DW{busy_s & grant_q[i]}});
      s_sel   = s_sel   | (m_sel[i*SW +: SW]   & {SW{busy_s & grant_q[i]}});
    end
    m_ack   = {N_MASTERS{s_ack & busy_s}} & grant_q;
    m_err   = {N_MASTERS{s_err & busy_s}} & grant_q;
    m_dat_r = s_dat_r;
    grant   = grant_q;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a random soak,
// every cycle compared against a queue-free ownership model of the arbitration rules.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    cyc, stb, we;
  logic [AW-1:0]   adr [N];
  logic [DW-1:0]   dat [N];
  logic [SW-1:0]   sel [N];
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_dat_r, s_dat_w, s_dat_r;
  logic [N-1:0]    m_ack, m_err, grant;
  logic            s_cyc, s_stb, s_we, s_ack, s_err;
  logic [AW-1:0]   s_adr;
  logic [SW-1:0]   s_sel;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign m_adr[g*AW +: AW]   = adr[g];
    assign m_dat_w[g*DW +: DW] = dat[g];
    assign m_sel[g*SW +: SW]   = sel[g];
  end

  wb_arbiter #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(cyc), .m_stb(stb), .m_we(we), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int owner;
  int model_last;
  int last_beat = -1;
  int n_xfer_model [N];
  int n_xfer_dut [N];
  int wait_cnt [N];
  int beats [N];
  logic [N-1:0] prev_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h, required %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner      = -1;
    model_last = N - 1;
  endtask

  // Arbitration rules: idle picks first requester after last owner; owner keeps bus until CYC drops.
  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (owner < 0 && cyc[(model_last + k) % N]) owner = (model_last + k) % N;
      end
    end else if (!cyc[owner]) begin
      model_last = owner;
      owner      = -1;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      e_cyc = cyc[owner]; e_stb = stb[owner]; e_we = we[owner];
      e_adr = adr[owner]; e_dat = dat[owner]; e_sel = sel[owner];
      e_ack[owner] = s_ack;
      e_err[owner] = s_err;
    end
    check("grant",   64'(grant),   64'(e_grant));
    check("s_cyc",   64'(s_cyc),   64'(e_cyc));
    check("s_stb",   64'(s_stb),   64'(e_stb));
    check("s_we",    64'(s_we),    64'(e_we));
    check("s_adr",   64'(s_adr),   64'(e_adr));
    check("s_dat_w", 64'(s_dat_w), 64'(e_dat));
    check("s_sel",   64'(s_sel),   64'(e_sel));
    check("m_ack",   64'(m_ack),   64'(e_ack));
    check("m_err",   64'(m_err),   64'(e_err));
    check("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
    if (s_cyc && s_stb && (s_ack || s_err)) begin
      check("xfer_onehot", 64'($countones(m_ack | m_err)), 64'(1));
      for (int i = 0; i < N; i++) if (m_ack[i] || m_err[i]) n_xfer_dut[i]++;
    end
  endtask

  // Called at a falling edge with inputs already driven: check, then advance one clock.
  task automatic tick();
    #1;
    compare_all();
    last_beat = -1;
    if (owner >= 0 && cyc[owner] && stb[owner] && (s_ack || s_err)) begin
      last_beat = owner;
      n_xfer_model[owner]++;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic new_payload(input int i);
    adr[i] = $urandom;
    dat[i] = $urandom;
    sel[i] = SW'($urandom);
    we[i]  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [N-1:0] e;
    rst = 1'b1; cyc = '0; stb = '0; we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    for (int i = 0; i < N; i++) begin
      adr[i] = '0; dat[i] = '0; sel[i] = '0;
      n_xfer_model[i] = 0; n_xfer_dut[i] = 0; wait_cnt[i] = 0; beats[i] = 0;
    end
    model_reset();
    @(negedge clk);
    tick();
    check("rst_grant", 64'(grant), 64'(0));
    rst = 1'b0;
    tick();

    // Single master m1 write: one clock of latency, ACK only to m1.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h0000_0100; dat[1] = 32'hDEAD_BEEF; sel[1] = 4'hF;
    #1 check("t2_lat0", 64'(s_cyc), 64'(0));
    tick();
    #1 check("t2_cyc", 64'(s_cyc), 64'(1));
    check("t2_adr", 64'(s_adr), 64'(32'h0000_0100));
    check("t2_dat", 64'(s_dat_w), 64'(32'hDEAD_BEEF));
    s_ack = 1'b1;
    #1 check("t2_ack", 64'(m_ack), 64'(4'b0010));
    tick();
    s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    tick();

    // Reset in the middle of m2's cycle drops s_cyc and grant immediately.
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h0000_0200;
    tick();
    tick();
    s_ack = 1'b1;
    #2 rst = 1'b1;
    #1 check("t1_cyc", 64'(s_cyc), 64'(0));
    check("t1_grant", 64'(grant), 64'(0));
    check("t1_ack", 64'(m_ack), 64'(0));
    model_reset();
    s_ack = 1'b0;
    tick();
    cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // All four request together: order 0,1,2,3,0 with an idle clock between owners.
    cyc = '1; stb = '0;
    for (int g = 0; g < 5; g++) begin
      tick();
      e = '0; e[g % N] = 1'b1;
      check("t3_order", 64'(grant), 64'(e));
      cyc[g % N] = 1'b0;
      tick();
      check("t3_gap", 64'(grant), 64'(0));
      cyc[g % N] = 1'b1;
    end
    cyc = '0;
    tick();
    tick();

    // m0 holds a 4-beat burst while m1 waits; m1 never sees those ACKs.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0000_0400;
    tick();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      adr[0] = 32'h0000_0400 + 32'(b * 4);
      #1 check("t4_ack", 64'(m_ack), 64'(4'b0001));
      tick();
    end
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    check("t4_gap", 64'(grant), 64'(0));
    tick();
    check("t4_m1", 64'(grant), 64'(4'b0010));
    cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    tick();

    // Error response on m2's beat goes to m_err[2] only.
    cyc[2] = 1'b1; stb[2] = 1'b1;
    tick();
    s_err = 1'b1;
    #1 check("t5_err", 64'(m_err), 64'(4'b0100));
    check("t5_ack", 64'(m_ack), 64'(0));
    tick();
    s_err = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();
    tick();
    s_ack = 1'b1;
    #1 check("idle_ack", 64'(m_ack), 64'(0));
    tick();
    s_ack = 1'b0;

    // Random soak with bounded-wait fairness tracking from the observed grants.
    prev_grant = grant;
    for (int c = 0; c < 10000; c++) begin
      if (grant != '0 && prev_grant == '0) begin
        int o;
        o = 0;
        for (int i = 0; i < N; i++) if (grant[i]) o = i;
        check("fair_wait", 64'(wait_cnt[o] < N), 64'(1));
        wait_cnt[o] = 0;
        for (int j = 0; j < N; j++) if (j != o && cyc[j]) wait_cnt[j]++;
      end
      prev_grant = grant;
      for (int i = 0; i < N; i++) begin
        if (!cyc[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            cyc[i] = 1'b1; stb[i] = 1'b1;
            beats[i] = int'($urandom_range(1, 4));
            wait_cnt[i] = 0;
            new_payload(i);
          end else begin
            stb[i] = 1'b0;
          end
        end else if (owner == i) begin
          if (last_beat == i) begin
            beats[i]--;
            new_payload(i);
          end
          if (beats[i] <= 0 || $urandom_range(0, 31) == 0) begin
            cyc[i] = 1'b0;
            stb[i] = 1'($urandom_range(0, 1));
          end else begin
            stb[i] = ($urandom_range(0, 3) != 0);
          end
        end
      end
      begin
        int r;
        r = int'($urandom_range(0, 7));
        s_ack = (r < 3);
        s_err = (r == 3);
        s_dat_r = $urandom;
      end
      tick();
    end

    for (int i = 0; i < N; i++) check("xfer_count", 64'(n_xfer_dut[i]), 64'(n_xfer_model[i]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
